psubsb_serial: RTL and testbench

//  Multi-cycle packed saturating subtract (Sum = A - B per signed lane), companion to the

---
 rtl/psubsb_serial_if.sv | 27 ++
 rtl/psubsb_serial.sv | 118 +++++++++++
 tb/tb_psubsb_serial.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/psubsb_serial_if.sv
// Start/result handshake bundle for the serial packed saturating subtractor.
// The requester drives start and operands; the subtractor answers with status and results.
interface psubsb_serial_if #(
    parameter int LANES  = 4,
    parameter int LANE_W = 4
);
    localparam int W = LANES * LANE_W;

    logic             start;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic             ready;
    logic             busy;
    logic             done;
    logic [W-1:0]     Result;
    logic [LANES-1:0] SatFlags;

    modport master (
        output start, A, B,
        input  ready, busy, done, Result, SatFlags
    );

    modport slave (
        input  start, A, B,
        output ready, busy, done, Result, SatFlags
    );
endinterface

// File: rtl/psubsb_serial.sv
// Packed signed saturating subtract, one lane per clock through a shared LANE_W subtractor.
// Lanes are processed LSB first; Result and SatFlags hold until the next accepted start.
module psubsb_serial #(
    parameter int LANES  = 4,
    parameter int LANE_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    psubsb_serial_if.slave    bus
);
    // state  | meaning
    // S_IDLE | no job since reset, ready for start
    // S_BUSY | one lane written per cycle, counter selects the lane
    // S_DONE | Result/SatFlags valid and held, ready for start
    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    localparam int W  = LANES * LANE_W;
    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     result_q, result_d;
    logic [LANES-1:0] sat_q, sat_d;
    logic             done_q, done_d;

    logic [LANE_W-1:0] a_lane;
    logic [LANE_W-1:0] b_lane;
    logic [LANE_W-1:0] diff;
    logic [LANE_W-1:0] lane_res;
    logic              sat_pos;
    logic              sat_neg;

    // Overflow is detected from the sign bits alone, so B = most-negative needs no special case.
    always_comb begin
        a_lane  = a_q[cnt_q*LANE_W +: LANE_W];
        b_lane  = b_q[cnt_q*LANE_W +: LANE_W];
        diff    = a_lane + ~b_lane + LANE_W'(1);
        sat_pos = ~a_lane[LANE_W-1] &  b_lane[LANE_W-1] &  diff[LANE_W-1];
        sat_neg =  a_lane[LANE_W-1] & ~b_lane[LANE_W-1] & ~diff[LANE_W-1];
        if (sat_pos) begin
            lane_res = {1'b0, {(LANE_W-1){1'b1}}};
        end else if (sat_neg) begin
            lane_res = {1'b1, {(LANE_W-1){1'b0}}};
        end else begin
            lane_res = diff;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        sat_d    = sat_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d  = S_BUSY;
                    cnt_d    = '0;
                    a_d      = bus.A;
                    b_d      = bus.B;
                    result_d = '0;
                    sat_d    = '0;
                end
            end
            S_BUSY: begin
                result_d[cnt_q*LANE_W +: LANE_W] = lane_res;
                sat_d[cnt_q] = sat_pos | sat_neg;
                if (cnt_q == LAST_LANE) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            sat_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            sat_q    <= sat_d;
            done_q   <= done_d;
        end
    end

    assign bus.ready    = (state_q == S_IDLE) || (state_q == S_DONE);
    assign bus.busy     = (state_q == S_BUSY);
    assign bus.done     = done_q;
    assign bus.Result   = result_q;
    assign bus.SatFlags = sat_q;
endmodule

// File: tb/tb_psubsb_serial.sv
// Bench for psubsb_serial: directed vectors plus random jobs, scoreboarded against
// an integer-arithmetic saturating subtract model with done-timing checks.
module tb_psubsb_serial;
    localparam int LANES  = 4;
    localparam int LANE_W = 4;
    localparam int W      = LANES * LANE_W;
    localparam int N_RAND = 10000;

    typedef struct {
        logic [W-1:0]     r;
        logic [LANES-1:0] f;
        int               due;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;
    exp_t sb_q[$];

    psubsb_serial_if #(.LANES(LANES), .LANE_W(LANE_W)) bus();

    psubsb_serial #(.LANES(LANES), .LANE_W(LANE_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: true signed difference per lane, clamped to the lane range.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic [LANES-1:0] f);
        int hi;
        int lo;
        hi = (1 << (LANE_W - 1)) - 1;
        lo = -(1 << (LANE_W - 1));
        r  = '0;
        f  = '0;
        for (int i = 0; i < LANES; i++) begin
            int ai;
            int bi;
            int d;
            ai = $signed(a[i*LANE_W +: LANE_W]);
            bi = $signed(b[i*LANE_W +: LANE_W]);
            d  = ai - bi;
            if (d > hi) begin
                d    = hi;
                f[i] = 1'b1;
            end else if (d < lo) begin
                d    = lo;
                f[i] = 1'b1;
            end
            r[i*LANE_W +: LANE_W] = LANE_W'(d);
        end
    endfunction

    // Monitor: pops an expectation on every done pulse and checks values and timing.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'(bus.done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("result", 32'(bus.Result), 32'(e.r));
                    check("satflags", 32'(bus.SatFlags), 32'(e.f));
                    check("done_cycle", 32'(cyc), 32'(e.due));
                    check("ready_at_done", 32'(bus.ready), 32'd1);
                end
            end else if (sb_q.size() != 0 && cyc >= sb_q[0].due) begin
                exp_t e;
                e = sb_q.pop_front();
                check("done_missing", 32'(bus.done), 32'd1);
            end
        end
    end

    // Drives one cycle from a negedge; an accepted start queues its expected response.
    task automatic drive_cycle(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = s;
        bus.A     = a;
        bus.B     = b;
        if (s && bus.ready && !rst) begin
            exp_t e;
            model(a, b, e.r, e.f);
            e.due = cyc + 1 + LANES;
            sb_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 4 * LANES) begin
            drive_cycle(1'b0, '0, '0);
            n++;
        end
        if (sb_q.size() != 0) check("drain_timeout", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic run_vec(input logic [W-1:0] a, input logic [W-1:0] b);
        drive_cycle(1'b1, a, b);
        drain();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset_result", 32'(bus.Result), 32'd0);
        check("reset_satflags", 32'(bus.SatFlags), 32'd0);
        check("reset_ready", 32'(bus.ready), 32'd1);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);

        run_vec(16'h7F80, 16'hF108);
        check("vec2_const", 32'(bus.Result), 32'h7E87);
        check("vec2_flags", 32'(bus.SatFlags), 32'b1001);
        run_vec(16'h8421, 16'h1111);
        check("vec3_const", 32'(bus.Result), 32'h8310);
        check("vec3_flags", 32'(bus.SatFlags), 32'b1000);
        run_vec(16'h3333, 16'h1234);
        check("vec4_const", 32'(bus.Result), 32'h210F);
        check("vec4_flags", 32'(bus.SatFlags), 32'b0000);
        run_vec(16'h0F0F, 16'h8888);
        check("held_after_done", 32'(bus.Result), 32'h7777);

        // start held through BUSY with changing operands; the last drive lands in the done cycle
        drive_cycle(1'b1, 16'h1234, 16'h4321);
        check("busy_while_running", 32'(bus.busy), 32'd1);
        for (int k = 0; k < LANES; k++) begin
            drive_cycle(1'b1, W'($urandom), W'($urandom));
        end
        drain();

        // reset during BUSY cycle 2 discards the job
        drive_cycle(1'b1, 16'h7777, 16'h8888);
        drive_cycle(1'b0, '0, '0);
        check("partial_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_ready", 32'(bus.ready), 32'd1);
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_result", 32'(bus.Result), 32'd0);
        check("rst_mid_flags", 32'(bus.SatFlags), 32'd0);
        repeat (2 * LANES) drive_cycle(1'b0, '0, '0);

        begin
            int jobs;
            int guard;
            jobs  = 0;
            guard = 0;
            while (jobs < N_RAND && guard < 8 * N_RAND) begin
                logic s;
                s = ($urandom_range(0, 7) != 0);
                if (s && bus.ready) jobs++;
                drive_cycle(s, W'($urandom), W'($urandom));
                guard++;
            end
            if (jobs < N_RAND) check("random_jobs", 32'(jobs), 32'(N_RAND));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
